frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader_pkg.sv | 18 +
 rtl/frame_loader.sv | 105 ++++++++++
 tb/tb_frame_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_pkg.sv
// Shared frame geometry defaults and the loader FSM encoding, used by the
// frame loader and the display path.
package frame_loader_pkg;

  localparam int IMG_W_DEF  = 300;
  localparam int IMG_H_DEF  = 200;
  localparam int ADDR_W_DEF = 16;
  localparam int PIX_W_DEF  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/frame_loader.sv
// Streams byte pairs into 4:4:4 pixels and writes them linearly into the
// frame memory, one pixel per three clocks at best.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_din,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  din_q, din_d;
  logic [7:0]        hi_q, hi_d;
  logic              xfer;

  // Every output is a decode of registered state, so none can glitch on inputs.
  assign s_ready  = (state_q == ST_HI) || (state_q == ST_LO);
  assign mem_en   = (state_q == ST_WR);
  assign mem_we   = (state_q == ST_WR);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign xfer     = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    hi_d    = hi_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_d   = '0;
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          if (xfer) begin
            hi_d    = s_data;
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          // Address/data are latched here so they stay stable after WR.
          if (xfer) begin
            addr_d  = cnt_q;
            din_d   = PIX_W'({hi_q, s_data[3:0]});
            state_d = ST_WR;
          end
        end
        ST_WR: begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_HI;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader on a reduced 6x4 frame.
module tb_frame_loader;

  localparam int W = 6;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [11:0] mem_din;
  logic        busy;
  logic        done;

  int n_assert;
  int n_fail;
  int wr_n;
  int done_n;
  int ncyc;
  logic [7:0]  wr_addr [0:63];
  logic [11:0] wr_din  [0:63];

  frame_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(8), .PIX_W(12)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done monitor: samples what the memory would latch at each edge.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n[5:0]] = mem_addr;
        wr_din[wr_n[5:0]]  = mem_din;
      end
      wr_n = wr_n + 1;
    end
    if (done === 1'b1) done_n = done_n + 1;
  end

  function automatic logic [7:0] hi_b(input int p);
    return 8'(p * 37 + 5);
  endfunction

  function automatic logic [7:0] lo_b(input int p);
    return 8'(p * 11 + 192);
  endfunction

  function automatic logic [11:0] pix(input int p);
    logic [7:0] lb;
    lb = lo_b(p);
    return {hi_b(p), lb[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] hb, input logic [7:0] lb);
    s_valid = 1'b1;
    s_data  = hb;
    step();
    s_data = lb;
    step();
    s_valid = 1'b0;
    s_data  = 8'hEE;
    step();
  endtask

  // Handshake-driven byte feeder; stops on done or on a write at stop_addr.
  task automatic stream(input bit rnd, input int stop_addr, output int cyc);
    int  idx;
    bit  fire;
    bit  fin;
    idx = 0;
    fin = 1'b0;
    cyc = 0;
    s_data  = hi_b(0);
    s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 2000 && !fin; c++) begin
      fire = s_valid && s_ready;
      step();
      if (fire) idx++;
      s_data = (idx % 2 == 0) ? hi_b(idx / 2) : lo_b(idx / 2);
      if (rnd) s_valid = 1'($urandom_range(0, 1));
      if (done) begin
        fin = 1'b1;
        cyc = c + 1;
      end
      if (stop_addr >= 0 && mem_we && int'(mem_addr) == stop_addr) fin = 1'b1;
    end
    s_valid = 1'b0;
    if (!fin) chk("stream_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_wr_count"}, wr_n, NPIX);
    for (int i = 0; i < NPIX; i++) begin
      chk({tag, "_addr"}, 32'(wr_addr[i]), i);
      chk({tag, "_din"}, 32'(wr_din[i]), 32'(pix(i)));
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    wr_n     = 0;
    done_n   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    repeat (2) step();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();

    // Bytes offered in IDLE are not taken.
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    chk("idle_s_ready", 32'(s_ready), 0);
    chk("idle_busy", 32'(busy), 0);

    // First pixel A5/0C with s_valid held high.
    start  = 1'b1;
    s_data = 8'hA5;
    step();
    start = 1'b0;
    chk("hi_busy", 32'(busy), 1);
    chk("hi_s_ready", 32'(s_ready), 1);
    chk("hi_no_we", 32'(mem_we), 0);
    step();
    chk("lo_s_ready", 32'(s_ready), 1);
    chk("lo_no_we", 32'(mem_we), 0);
    s_data = 8'h0C;
    step();
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_en", 32'(mem_en), 1);
    chk("wr_addr0", 32'(mem_addr), 0);
    chk("wr_din0", 32'(mem_din), 32'hA5C);
    chk("wr_s_ready", 32'(s_ready), 0);
    s_data = 8'h99;
    step();
    s_valid = 1'b0;
    chk("wr_fall_3cyc", 32'(mem_we), 0);
    chk("hold_addr", 32'(mem_addr), 0);
    chk("hold_din", 32'(mem_din), 32'hA5C);

    // start mid-frame is ignored; upper nibble of the LO byte is dropped.
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h12;
    step();
    start  = 1'b0;
    s_data = 8'hF3;
    step();
    chk("midstart_addr", 32'(mem_addr), 1);
    chk("midstart_din", 32'(mem_din), 32'h123);
    s_valid = 1'b0;
    step();
    chk("midstart_busy", 32'(busy), 1);

    // Stalls in HI and LO produce no writes.
    repeat (3) step();
    chk("stall_hi_ready", 32'(s_ready), 1);
    chk("stall_hi_we", 32'(mem_we), 0);
    s_valid = 1'b1;
    s_data  = 8'h6B;
    step();
    s_valid = 1'b0;
    repeat (3) step();
    chk("stall_lo_ready", 32'(s_ready), 1);
    chk("stall_lo_we", 32'(mem_we), 0);
    chk("stall_wr_count", wr_n, 2);
    s_valid = 1'b1;
    s_data  = 8'h47;
    step();
    chk("stall_addr", 32'(mem_addr), 2);
    chk("stall_din", 32'(mem_din), 32'h6B7);
    s_valid = 1'b0;
    step();

    for (int p = 3; p < 10; p++) send_pix(hi_b(p), lo_b(p));
    chk("pre_abort_count", wr_n, 10);
    chk("pre_abort_din9", 32'(wr_din[9]), 32'(pix(9)));

    // Abort after the HI byte of pixel 10, racing a transfer and a start.
    s_valid = 1'b1;
    s_data  = hi_b(10);
    step();
    s_data = lo_b(10);
    abort  = 1'b1;
    start  = 1'b1;
    step();
    abort   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_s_ready", 32'(s_ready), 0);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_hold_addr", 32'(mem_addr), 9);
    repeat (3) step();
    chk("abort_no_write", wr_n, 10);
    chk("abort_no_done", done_n, 0);

    // Full frame back-to-back from address 0.
    wr_n   = 0;
    done_n = 0;
    start  = 1'b1;
    step();
    start = 1'b0;
    stream(1'b0, -1, ncyc);
    chk("full_cycles", ncyc, 3 * NPIX);
    chk("full_done", 32'(done), 1);
    chk("full_done_busy", 32'(busy), 1);
    step();
    chk("full_done_pulse", 32'(done), 0);
    chk("full_busy_fall", 32'(busy), 0);
    chk("full_no_wrap", 32'(mem_addr), NPIX - 1);
    chk("full_done_count", done_n, 1);
    chk_frame("full");

    // Full frame with random s_valid gaps.
    wr_n   = 0;
    done_n = 0;
    start  = 1'b1;
    step();
    start = 1'b0;
    stream(1'b1, -1, ncyc);
    step();
    chk("rand_done_count", done_n, 1);
    chk("rand_busy", 32'(busy), 0);
    chk_frame("rand");

    // Reset dropped in the middle of the WR cycle for address 15.
    wr_n  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    stream(1'b0, 15, ncyc);
    chk("rstwr_in_wr", 32'(mem_we), 1);
    chk("rstwr_addr", 32'(mem_addr), 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwr_async_we", 32'(mem_we), 0);
    chk("rstwr_en", 32'(mem_en), 0);
    chk("rstwr_busy", 32'(busy), 0);
    chk("rstwr_ready", 32'(s_ready), 0);
    chk("rstwr_mem_addr", 32'(mem_addr), 0);
    chk("rstwr_mem_din", 32'(mem_din), 0);
    chk("rstwr_done", 32'(done), 0);
    repeat (2) step();
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    repeat (8) step();
    s_valid = 1'b0;
    chk("rstwr_no_write", wr_n, 15);
    chk("rstwr_idle", 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    send_pix(8'hC3, 8'h5E);
    chk("restart_count", wr_n, 16);
    chk("restart_addr", 32'(wr_addr[15]), 0);
    chk("restart_din", 32'(wr_din[15]), 32'hC3E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
